// File: rtl/jump_charge_ctrl.sv
// jump_charge_ctrl: turns a debounced button hold into a jump distance and
// hands one jump at a time to the game FSM through a ready/start/done handshake.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   btn         raw asynchronous push button, active-high
//   game_ready  game FSM idle and able to accept a jump
//   jump_done   one-cycle pulse from the game FSM: jump finished
//   jump_start  one-cycle pulse: start a jump using jump_dist
//   jump_dist   charged distance, held from jump_start until the next charge
//   charging    high while charging
//   busy        high while a jump is being issued or is in flight
//   timeout     sticky: the game FSM never completed a jump; cleared by rst
module jump_charge_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned DIST_MIN     = 13,
  parameter int unsigned DIST_MAX     = 31,
  parameter int unsigned BUSY_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       game_ready,
  input  logic       jump_done,
  output logic       jump_start,
  output logic [7:0] jump_dist,
  output logic       charging,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned DIST_W = 8;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BSY_W  = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHARGE,
    S_ISSUE,
    S_BUSY
  } state_t;

  state_t             state;
  logic [1:0]         sync_q;
  logic               btn_db;
  logic [DB_W-1:0]    db_cnt;
  logic               armed;
  logic [PRE_W-1:0]   pre_cnt;
  logic [BSY_W-1:0]   bsy_cnt;

  logic               btn_s_c;
  logic               db_diff_c;
  logic               db_toggle_c;
  logic               rise_c;
  logic               fall_c;
  logic               pre_last_c;
  logic               dist_at_max_c;
  logic               bsy_last_c;

  // Debounce decisions and counter terminal conditions.
  // rise/fall are reported on the same edge btn_db changes, so the FSM reacts
  // together with the debounced level rather than one cycle later.
  always_comb begin
    btn_s_c       = sync_q[1];
    db_diff_c     = btn_s_c ^ btn_db;
    db_toggle_c   = db_diff_c && (db_cnt == DB_W'(DEBOUNCE_CYC));
    rise_c        = db_toggle_c && !btn_db;
    fall_c        = db_toggle_c && btn_db;
    pre_last_c    = (pre_cnt == PRE_W'(TICK_DIV - 1));
    dist_at_max_c = (jump_dist >= DIST_W'(DIST_MAX));
    bsy_last_c    = (bsy_cnt == BSY_W'(BUSY_TIMEOUT - 2));
  end

  // Two-flop synchroniser and debounce counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
      if (!db_diff_c) begin
        db_cnt <= '0;
      end else if (db_toggle_c) begin
        btn_db <= ~btn_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Jump sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      armed      <= 1'b1;
      pre_cnt    <= '0;
      bsy_cnt    <= '0;
      jump_start <= 1'b0;
      jump_dist  <= '0;
      charging   <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      jump_start <= 1'b0;
      case (state)
        S_IDLE: begin
          // Re-arm only once the button is seen released while idle.
          if (!btn_db) armed <= 1'b1;
          if (rise_c && armed && game_ready) begin
            state     <= S_CHARGE;
            charging  <= 1'b1;
            armed     <= 1'b0;
            jump_dist <= DIST_W'(DIST_MIN);
            pre_cnt   <= '0;
          end
        end
        S_CHARGE: begin
          // Abort beats release, release beats a distance tick.
          if (!game_ready) begin
            state    <= S_IDLE;
            charging <= 1'b0;
          end else if (fall_c) begin
            state      <= S_ISSUE;
            charging   <= 1'b0;
            busy       <= 1'b1;
            jump_start <= 1'b1;
          end else if (pre_last_c) begin
            pre_cnt <= '0;
            if (!dist_at_max_c) jump_dist <= jump_dist + DIST_W'(1);
          end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
          end
        end
        S_ISSUE: begin
          state   <= S_BUSY;
          bsy_cnt <= '0;
        end
        S_BUSY: begin
          // Completion on the expiry cycle wins over the timeout.
          if (jump_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (bsy_last_c) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            bsy_cnt <= bsy_cnt + BSY_W'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          charging <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_charge_ctrl.sv
// Bench for jump_charge_ctrl: directed segment table with hand-derived
// expectations, then randomized stimulus against a behavioural model.
module tb_jump_charge_ctrl;

  localparam int unsigned D   = 2;
  localparam int unsigned TD  = 4;
  localparam int unsigned MIN = 13;
  localparam int unsigned MAX = 16;
  localparam int unsigned BTO = 20;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       game_ready;
  logic       jump_done;
  logic       jump_start;
  logic [7:0] jump_dist;
  logic       charging;
  logic       busy;
  logic       timeout;

  jump_charge_ctrl #(
    .DEBOUNCE_CYC(D),
    .TICK_DIV(TD),
    .DIST_MIN(MIN),
    .DIST_MAX(MAX),
    .BUSY_TIMEOUT(BTO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .game_ready(game_ready),
    .jump_done(jump_done),
    .jump_start(jump_start),
    .jump_dist(jump_dist),
    .charging(charging),
    .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_CHG = 1, M_ISS = 2, M_BSY = 3;

  bit       m_valid = 0;
  bit       m_s1, m_s2;
  bit       m_win[$];
  bit       m_db;
  bit       m_armed;
  int       m_mode;
  int       m_k;
  int       m_n;
  int       m_dist;
  bit       m_to;

  task automatic model_step(input bit b, input bit g, input bit d, input bit r);
    bit bs, tog, rise, fall;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_win.delete();
      m_db = 0; m_armed = 1; m_mode = M_IDLE;
      m_k = 0; m_n = 0; m_dist = 0; m_to = 0; m_valid = 1;
      return;
    end
    bs = m_s2; m_s2 = m_s1; m_s1 = b;
    // Debounced level flips once D+1 successive samples disagree with it.
    m_win.push_back(bs);
    if (m_win.size() > D + 1) void'(m_win.pop_front());
    tog = (m_win.size() == D + 1);
    foreach (m_win[i]) if (m_win[i] == m_db) tog = 0;
    rise = tog && !m_db;
    fall = tog && m_db;
    case (m_mode)
      M_IDLE: begin
        if (rise && m_armed && g) begin
          m_mode = M_CHG; m_k = 0; m_dist = MIN; m_armed = 0;
        end else if (!m_db) begin
          m_armed = 1;
        end
      end
      M_CHG: begin
        if (!g) m_mode = M_IDLE;
        else if (fall) m_mode = M_ISS;
        else begin
          m_k++;
          m_dist = (MIN + m_k / TD > MAX) ? MAX : MIN + m_k / TD;
        end
      end
      M_ISS: begin
        m_mode = M_BSY; m_n = 0;
      end
      default: begin
        if (d) m_mode = M_IDLE;
        else begin
          m_n++;
          if (m_n == BTO - 1) begin m_mode = M_IDLE; m_to = 1; end
        end
      end
    endcase
    if (tog) m_db = !m_db;
  endtask

  task automatic check_model();
    logic [11:0] got, exp;
    if (!m_valid) return;
    got = {charging, busy, jump_start, timeout, jump_dist};
    exp = {m_mode == M_CHG, m_mode == M_ISS || m_mode == M_BSY, m_mode == M_ISS,
           m_to, 8'(m_dist)};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL model t=%0t got chg/busy/start/to/dist=%b/%b/%b/%b/%0d exp %b/%b/%b/%b/%0d",
               $time, got[11], got[10], got[9], got[8], got[7:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // One clock: drive inputs, step model with the sampled values, check after the edge.
  task automatic tick(input bit b, input bit g, input bit d, input bit r);
    btn = b; game_ready = g; jump_done = d; rst = r;
    @(posedge clk);
    model_step(b, g, d, r);
    #1;
    check_model();
  endtask

  // ---------------- directed segment table ----------------
  typedef struct {
    bit         b, g, d, r;
    int         cyc;
    bit         e_chg, e_busy, e_to;
    logic [7:0] e_dist;
    int         e_starts;
  } seg_t;

  seg_t tbl[$];

  task automatic add(input bit b, input bit g, input bit d, input bit r, input int cyc,
                     input bit ec, input bit eb, input bit et, input int ed, input int es);
    seg_t s;
    s.b = b; s.g = g; s.d = d; s.r = r; s.cyc = cyc;
    s.e_chg = ec; s.e_busy = eb; s.e_to = et; s.e_dist = 8'(ed); s.e_starts = es;
    tbl.push_back(s);
  endtask

  initial begin
    int starts;
    int hold;
    bit rb;
    btn = 0; game_ready = 1; jump_done = 0; rst = 1;

    //   b g d r cyc  chg busy to dist starts
    add(0,1,0,1, 2,  0,0,0, 0,0);
    // charge, 12 cycles, release, complete
    add(1,1,0,0, 4,  0,0,0, 0,0);
    add(1,1,0,0, 1,  1,0,0,13,0);
    add(1,1,0,0,12,  1,0,0,16,0);
    add(0,1,0,0, 4,  1,0,0,16,0);
    add(0,1,0,0, 1,  0,1,0,16,1);
    add(0,1,0,0, 5,  0,1,0,16,0);
    add(0,1,1,0, 1,  0,0,0,16,0);
    add(0,1,0,0, 2,  0,0,0,16,0);
    // saturation, then a two-cycle glitch
    add(1,1,0,0, 5,  1,0,0,13,0);
    add(1,1,0,0,40,  1,0,0,16,0);
    add(0,1,0,0, 4,  1,0,0,16,0);
    add(0,1,0,0, 1,  0,1,0,16,1);
    add(0,1,0,0, 1,  0,1,0,16,0);
    add(0,1,1,0, 1,  0,0,0,16,0);
    add(1,1,0,0, 2,  0,0,0,16,0);
    add(0,1,0,0, 8,  0,0,0,16,0);
    // abort keeps partial distance; press without ready ignored
    add(1,1,0,0, 5,  1,0,0,13,0);
    add(1,1,0,0, 6,  1,0,0,14,0);
    add(1,0,0,0, 1,  0,0,0,14,0);
    add(0,0,0,0, 8,  0,0,0,14,0);
    add(1,0,0,0, 8,  0,0,0,14,0);
    add(1,1,0,0, 3,  0,0,0,14,0);
    add(0,1,0,0, 8,  0,0,0,14,0);
    // button held through completion needs release + fresh press
    add(1,1,0,0, 5,  1,0,0,13,0);
    add(1,1,0,0, 3,  1,0,0,13,0);
    add(0,1,0,0, 5,  0,1,0,14,1);
    add(1,1,0,0, 6,  0,1,0,14,0);
    add(1,1,1,0, 1,  0,0,0,14,0);
    add(1,1,0,0,10,  0,0,0,14,0);
    add(0,1,0,0, 8,  0,0,0,14,0);
    add(1,1,0,0, 5,  1,0,0,13,0);
    add(1,0,0,0, 1,  0,0,0,13,0);
    add(0,1,0,0, 8,  0,0,0,13,0);
    // timeout sticky; completion on expiry cycle wins
    add(1,1,0,0, 5,  1,0,0,13,0);
    add(0,1,0,0, 5,  0,1,0,14,1);
    add(0,1,0,0,19,  0,1,0,14,0);
    add(0,1,0,0, 1,  0,0,1,14,0);
    add(0,1,0,0, 5,  0,0,1,14,0);
    add(0,1,0,1, 1,  0,0,0, 0,0);
    add(1,1,0,0, 5,  1,0,0,13,0);
    add(0,1,0,0, 5,  0,1,0,14,1);
    add(0,1,0,0,19,  0,1,0,14,0);
    add(0,1,1,0, 1,  0,0,0,14,0);
    // reset during charge and during busy
    add(1,1,0,0, 5,  1,0,0,13,0);
    add(0,1,0,1, 1,  0,0,0, 0,0);
    add(0,1,0,0, 8,  0,0,0, 0,0);
    add(1,1,0,0, 5,  1,0,0,13,0);
    add(0,1,0,0, 5,  0,1,0,14,1);
    add(0,1,0,0, 3,  0,1,0,14,0);
    add(0,1,0,1, 1,  0,0,0, 0,0);
    add(0,1,0,0, 5,  0,0,0, 0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      starts = 0;
      for (int c = 0; c < tbl[i].cyc; c++) begin
        tick(tbl[i].b, tbl[i].g, tbl[i].d, tbl[i].r);
        if (jump_start === 1'b1) starts++;
      end
      n_cmp++;
      if ({charging, busy, timeout} !== {tbl[i].e_chg, tbl[i].e_busy, tbl[i].e_to} ||
          jump_dist !== tbl[i].e_dist) begin
        n_bad++;
        $display("FAIL seg%0d outputs got chg/busy/to/dist=%b/%b/%b/%0d exp %b/%b/%b/%0d",
                 i, charging, busy, timeout, jump_dist,
                 tbl[i].e_chg, tbl[i].e_busy, tbl[i].e_to, tbl[i].e_dist);
      end
      n_cmp++;
      if (starts != tbl[i].e_starts) begin
        n_bad++;
        $display("FAIL seg%0d starts got %0d exp %0d", i, starts, tbl[i].e_starts);
      end
    end

    // Randomized phase: button levels held for random lengths, incl. glitches.
    tick(0, 1, 0, 1);
    for (int i = 0; i < 300; i++) begin
      rb   = ($urandom_range(0, 1) == 1);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
      for (int c = 0; c < hold; c++) begin
        tick(rb, $urandom_range(0, 15) != 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 499) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
